// File: rtl/vpu_pkg.sv
// Shared vector-processing-unit definitions: object slot sizing, request
// priority encoding and the geometry-unit operation codes.
package vpu_pkg;

  localparam int OBJ_SLOTS_DFLT = 32;
  localparam int OBJ_AW_DFLT    = $clog2(OBJ_SLOTS_DFLT);

  typedef logic [OBJ_AW_DFLT-1:0] obj_idx_t;

  // Listed in decreasing priority; REQ_NONE means nothing was accepted.
  typedef enum logic [2:0] {
    REQ_NONE     = 3'd0,
    REQ_DEL_ALL  = 3'd1,
    REQ_DEL_OBJ  = 3'd2,
    REQ_CRT_OBJ  = 3'd3,
    REQ_REF_ADDR = 3'd4,
    REQ_REF_NEXT = 3'd5
  } req_sel_e;

  // Operation codes the geometry unit uses when it talks about objects.
  localparam logic [2:0] GMT_OP_NOP     = 3'd0;
  localparam logic [2:0] GMT_OP_CRT     = 3'd1;
  localparam logic [2:0] GMT_OP_DEL     = 3'd2;
  localparam logic [2:0] GMT_OP_DEL_ALL = 3'd3;
  localparam logic [2:0] GMT_OP_REF     = 3'd4;
  localparam logic [2:0] GMT_OP_REF_NXT = 3'd5;

  function automatic req_sel_e req_decode(
    input logic d_all,
    input logic d_obj,
    input logic crt,
    input logic r_addr,
    input logic r_next
  );
    if (d_all)  return REQ_DEL_ALL;
    if (d_obj)  return REQ_DEL_OBJ;
    if (crt)    return REQ_CRT_OBJ;
    if (r_addr) return REQ_REF_ADDR;
    if (r_next) return REQ_REF_NEXT;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/object_unit_slot_finder.sv
// Combinational search for the lowest set bit of vec at or above start.
module slot_finder #(
  parameter int N  = 32,
  parameter int AW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [AW-1:0] start,
  output logic [AW-1:0] idx,
  output logic          found
);

  // Scanning downward lets the lowest qualifying bit win the last assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i] && (AW'(i) >= start)) begin
        idx   = AW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/object_unit.sv
// Object slot manager: allocates, frees and validates video-memory object
// slots for the geometry unit, answering each accepted request one cycle later.
module object_unit
  import vpu_pkg::*;
#(
  parameter int OBJ_SLOTS = OBJ_SLOTS_DFLT,
  localparam int AW = $clog2(OBJ_SLOTS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          crt_obj,
  input  logic          del_obj,
  input  logic          del_all,
  input  logic          ref_addr,
  input  logic          ref_next,
  input  logic [AW-1:0] obj_num_in,
  input  logic          clr_changed,
  output logic          busy,
  output logic          addr_vld,
  output logic [AW-1:0] obj_addr,
  output logic [AW-1:0] lst_stored_obj,
  output logic          lst_stored_obj_vld,
  output logic          req_err,
  output logic          obj_mem_full,
  output logic [AW:0]   obj_cnt,
  output logic          changed
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RESP = 1'b1;

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(OBJ_SLOTS);
  localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

  logic                 state;
  logic [OBJ_SLOTS-1:0] valid;
  logic [OBJ_SLOTS-1:0] valid_nxt;
  logic [AW:0]          cnt_nxt;
  logic [AW-1:0]        addr_nxt;
  logic [AW-1:0]        free_idx;
  logic                 free_found;
  logic [AW-1:0]        nxt_idx;
  logic                 nxt_found;
  logic                 hit;
  logic                 miss;
  logic                 crt_ok;
  logic                 set_chg;
  req_sel_e             req;

  assign busy = (state == ST_RESP);

  slot_finder #(.N(OBJ_SLOTS), .AW(AW)) u_free_find (
    .vec   (~valid),
    .start ('0),
    .idx   (free_idx),
    .found (free_found)
  );

  slot_finder #(.N(OBJ_SLOTS), .AW(AW)) u_next_find (
    .vec   (valid),
    .start (obj_num_in),
    .idx   (nxt_idx),
    .found (nxt_found)
  );

  always_comb begin
    req       = req_decode(del_all, del_obj, crt_obj, ref_addr, ref_next);
    valid_nxt = valid;
    cnt_nxt   = obj_cnt;
    addr_nxt  = obj_addr;
    hit       = 1'b0;
    miss      = 1'b0;
    crt_ok    = 1'b0;
    set_chg   = 1'b0;
    // Strobes arriving during the response cycle are dropped entirely.
    if (state != ST_IDLE) req = REQ_NONE;
    case (req)
      REQ_DEL_ALL: begin
        valid_nxt = '0;
        cnt_nxt   = '0;
        addr_nxt  = '0;
        hit       = 1'b1;
        set_chg   = |obj_cnt;
      end
      REQ_DEL_OBJ: begin
        if (valid[obj_num_in]) begin
          valid_nxt[obj_num_in] = 1'b0;
          cnt_nxt  = obj_cnt - ONE_CNT;
          addr_nxt = obj_num_in;
          hit      = 1'b1;
          set_chg  = 1'b1;
        end else begin
          miss = 1'b1;
        end
      end
      REQ_CRT_OBJ: begin
        if (free_found) begin
          valid_nxt[free_idx] = 1'b1;
          cnt_nxt  = obj_cnt + ONE_CNT;
          addr_nxt = free_idx;
          hit      = 1'b1;
          crt_ok   = 1'b1;
          set_chg  = 1'b1;
        end else begin
          miss = 1'b1;
        end
      end
      REQ_REF_ADDR: begin
        if (valid[obj_num_in]) begin
          addr_nxt = obj_num_in;
          hit      = 1'b1;
        end else begin
          miss = 1'b1;
        end
      end
      REQ_REF_NEXT: begin
        if (nxt_found) begin
          addr_nxt = nxt_idx;
          hit      = 1'b1;
        end else begin
          miss = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      valid              <= '0;
      obj_cnt            <= '0;
      obj_mem_full       <= 1'b0;
      obj_addr           <= '0;
      lst_stored_obj     <= '0;
      addr_vld           <= 1'b0;
      req_err            <= 1'b0;
      lst_stored_obj_vld <= 1'b0;
      changed            <= 1'b0;
    end else begin
      state              <= (req != REQ_NONE) ? ST_RESP : ST_IDLE;
      valid              <= valid_nxt;
      obj_cnt            <= cnt_nxt;
      obj_mem_full       <= (cnt_nxt == FULL_CNT);
      addr_vld           <= hit;
      req_err            <= miss;
      lst_stored_obj_vld <= crt_ok;
      if (hit)    obj_addr       <= addr_nxt;
      if (crt_ok) lst_stored_obj <= addr_nxt;
      // A request-driven set beats a coincident clear.
      if (set_chg)          changed <= 1'b1;
      else if (clr_changed) changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_object_unit.sv
// Scoreboard bench for object_unit: requests push expected responses, a
// negedge monitor pops and compares them against the response pulses.
module tb_object_unit;

  localparam int AW = 5;
  localparam logic [4:0] S_DALL = 5'b10000;
  localparam logic [4:0] S_DEL  = 5'b01000;
  localparam logic [4:0] S_CRT  = 5'b00100;
  localparam logic [4:0] S_REF  = 5'b00010;
  localparam logic [4:0] S_NXT  = 5'b00001;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          crt_obj, del_obj, del_all, ref_addr, ref_next, clr_changed;
  logic [AW-1:0] obj_num_in;
  logic          busy, addr_vld, lst_stored_obj_vld, req_err, obj_mem_full, changed;
  logic [AW-1:0] obj_addr, lst_stored_obj;
  logic [AW:0]   obj_cnt;

  typedef struct {
    logic          ok;
    logic [AW-1:0] addr;
    logic          lst;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  object_unit #(.OBJ_SLOTS(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .crt_obj            (crt_obj),
    .del_obj            (del_obj),
    .del_all            (del_all),
    .ref_addr           (ref_addr),
    .ref_next           (ref_next),
    .obj_num_in         (obj_num_in),
    .clr_changed        (clr_changed),
    .busy               (busy),
    .addr_vld           (addr_vld),
    .obj_addr           (obj_addr),
    .lst_stored_obj     (lst_stored_obj),
    .lst_stored_obj_vld (lst_stored_obj_vld),
    .req_err            (req_err),
    .obj_mem_full       (obj_mem_full),
    .obj_cnt            (obj_cnt),
    .changed            (changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && (addr_vld || req_err)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL resp_unexpected: addr_vld=%0b req_err=%0b obj_addr=%0d, none expected",
                 addr_vld, req_err, obj_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({addr_vld, req_err, lst_stored_obj_vld, busy} !== {e.ok, !e.ok, e.lst, 1'b1} ||
            (e.ok && obj_addr !== e.addr) || (e.lst && lst_stored_obj !== e.addr)) begin
          n_err++;
          $display("FAIL resp: got vld=%0b err=%0b lst_vld=%0b busy=%0b addr=%0d lst=%0d, want vld=%0b err=%0b lst_vld=%0b busy=1 addr=%0d",
                   addr_vld, req_err, lst_stored_obj_vld, busy, obj_addr, lst_stored_obj,
                   e.ok, !e.ok, e.lst, e.addr);
        end
      end
    end
  end

  // Issue one request and bound the wait for its response to the next cycle.
  task automatic req(input logic [4:0] strb, input int n, input logic ok,
                     input int addr, input logic lst);
    exp_t e;
    e.ok = ok; e.addr = addr[AW-1:0]; e.lst = lst;
    sb.push_back(e);
    {del_all, del_obj, crt_obj, ref_addr, ref_next} = strb;
    obj_num_in = n[AW-1:0];
    @(posedge clk); #1;
    {del_all, del_obj, crt_obj, ref_addr, ref_next} = '0;
    @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL resp_timeout: %0d responses outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {del_all, del_obj, crt_obj, ref_addr, ref_next, clr_changed} = '0;
    obj_num_in = '0;
    #12;
    n_checks++;
    if ({busy, addr_vld, req_err, lst_stored_obj_vld, obj_mem_full, changed} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, addr_vld, req_err, lst_stored_obj_vld, obj_mem_full, changed});
    end
    n_checks++;
    if ({obj_addr, lst_stored_obj, obj_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_values: obj_addr=%0d lst=%0d cnt=%0d want 0", obj_addr, lst_stored_obj, obj_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_create();
    for (int i = 0; i < 3; i++) req(S_CRT, 0, 1'b1, i, 1'b1);
    n_checks++;
    if (obj_cnt !== 6'd3 || changed !== 1'b1) begin
      n_err++;
      $display("FAIL create_state: cnt=%0d changed=%0b want 3 1", obj_cnt, changed);
    end
  endtask

  task automatic test_delete();
    req(S_DEL, 1, 1'b1, 1, 1'b0);
    req(S_CRT, 0, 1'b1, 1, 1'b1);
    req(S_DEL, 1, 1'b1, 1, 1'b0);
    req(S_DEL, 1, 1'b0, 0, 1'b0);
    n_checks++;
    if (obj_cnt !== 6'd2) begin
      n_err++;
      $display("FAIL delete_cnt: cnt=%0d want 2", obj_cnt);
    end
  endtask

  task automatic test_full();
    req(S_DALL, 0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 32; i++) req(S_CRT, 0, 1'b1, i, 1'b1);
    n_checks++;
    if (obj_mem_full !== 1'b1 || obj_cnt !== 6'd32) begin
      n_err++;
      $display("FAIL full_state: full=%0b cnt=%0d want 1 32", obj_mem_full, obj_cnt);
    end
    req(S_CRT, 0, 1'b0, 0, 1'b0);
    req(S_DEL, 31, 1'b1, 31, 1'b0);
    n_checks++;
    if (obj_mem_full !== 1'b0 || obj_cnt !== 6'd31) begin
      n_err++;
      $display("FAIL unfull_state: full=%0b cnt=%0d want 0 31", obj_mem_full, obj_cnt);
    end
    req(S_CRT, 0, 1'b1, 31, 1'b1);
  endtask

  task automatic test_ref();
    req(S_DALL, 0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 6; i++) req(S_CRT, 0, 1'b1, i, 1'b1);
    req(S_DEL, 0, 1'b1, 0, 1'b0);
    req(S_DEL, 1, 1'b1, 1, 1'b0);
    req(S_DEL, 3, 1'b1, 3, 1'b0);
    req(S_DEL, 4, 1'b1, 4, 1'b0);
    req(S_NXT, 3, 1'b1, 5, 1'b0);
    req(S_NXT, 6, 1'b0, 0, 1'b0);
    req(S_REF, 4, 1'b0, 0, 1'b0);
    req(S_REF, 2, 1'b1, 2, 1'b0);
    req(S_NXT, 0, 1'b1, 2, 1'b0);
    req(S_NXT, 5, 1'b1, 5, 1'b0);
  endtask

  task automatic test_priority();
    req(S_DALL | S_CRT, 0, 1'b1, 0, 1'b0);
    n_checks++;
    if (obj_cnt !== 6'd0) begin
      n_err++;
      $display("FAIL prio_del_all: cnt=%0d want 0", obj_cnt);
    end
    clr_changed = 1'b1;
    @(posedge clk); #1;
    clr_changed = 1'b0;
    n_checks++;
    if (changed !== 1'b0) begin
      n_err++;
      $display("FAIL clr_alone: changed=%0b want 0", changed);
    end
    req(S_DALL, 0, 1'b1, 0, 1'b0);
    n_checks++;
    if (changed !== 1'b0) begin
      n_err++;
      $display("FAIL del_all_empty: changed=%0b want 0", changed);
    end
    begin
      exp_t e;
      e.ok = 1'b1; e.addr = '0; e.lst = 1'b1;
      sb.push_back(e);
    end
    crt_obj = 1'b1; clr_changed = 1'b1;
    @(posedge clk); #1;
    crt_obj = 1'b0; clr_changed = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (changed !== 1'b1) begin
      n_err++;
      $display("FAIL set_over_clr: changed=%0b want 1", changed);
    end
    // A strobe held through the response cycle must yield one response only.
    begin
      exp_t e;
      e.ok = 1'b1; e.addr = 5'd1; e.lst = 1'b1;
      sb.push_back(e);
    end
    crt_obj = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    crt_obj = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (obj_cnt !== 6'd2 || sb.size() != 0) begin
      n_err++;
      $display("FAIL held_strobe: cnt=%0d pending=%0d want 2 0", obj_cnt, sb.size());
      sb.delete();
    end
    req(S_DEL | S_CRT, 1, 1'b1, 1, 1'b0);
    n_checks++;
    if (obj_cnt !== 6'd1) begin
      n_err++;
      $display("FAIL prio_del_obj: cnt=%0d want 1", obj_cnt);
    end
  endtask

  task automatic test_rst_resp();
    crt_obj = 1'b1;
    @(posedge clk); #1;
    crt_obj = 1'b0;
    n_checks++;
    if (addr_vld !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: addr_vld=%0b busy=%0b want 1 1", addr_vld, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({addr_vld, busy, lst_stored_obj_vld} !== 3'b0 || obj_cnt !== 6'd0) begin
      n_err++;
      $display("FAIL rst_in_resp: vld=%0b busy=%0b lst_vld=%0b cnt=%0d want 0 0 0 0",
               addr_vld, busy, lst_stored_obj_vld, obj_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    req(S_CRT, 0, 1'b1, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_create();
    test_delete();
    test_full();
    test_ref();
    test_priority();
    test_rst_resp();
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
